vga_pingpong_buf: RTL

Pixel line buffer directly upstream of vga_ctrl. It is filled from a 32-bit word stream (DMA/bus side) and serves one 12-bit pixel per cycle on vga_ctrl's data_req_o. It holds two banks: one is filled while the other is drained. A frame_start_i pulse flushes both banks at the vertical boundary. Sticky underrun_o flags any request served with no data.

---
 rtl/vga_pkg.sv | 13 +
 rtl/vga_pp_mem.sv | 28 ++
 rtl/vga_pingpong_buf.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel path: pixel width, packing of two pixels
// into a 32-bit bus word, and colour field positions inside one pixel.
package vga_pkg;

    localparam int PIX_W    = 12;
    localparam int PAIR_W   = 2 * PIX_W;
    localparam int PIX0_LSB = 0;
    localparam int PIX1_LSB = 16;
    localparam int R_LSB    = 0;
    localparam int G_LSB    = 4;
    localparam int B_LSB    = 8;

endpackage

// File: rtl/vga_pp_mem.sv
// Two-bank pixel-pair storage: synchronous write, combinational read.
// Address is {bank, word pointer}; contents are intentionally not reset.
module vga_pp_mem
    import vga_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW:0]       waddr,
    input  logic [PAIR_W-1:0] wdata,
    input  logic [AW:0]       raddr,
    output logic [PAIR_W-1:0] rdata
);

    logic [PAIR_W-1:0] mem_r [2*DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/vga_pingpong_buf.sv
// Ping-pong pixel line buffer: one bank fills from the 32-bit word stream while
// the other drains one 12-bit pixel per request; frame_start_i flushes both.
module vga_pingpong_buf
    import vga_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [31:0]      wr_data_i,
    input  logic             data_req_i,
    output logic [PIX_W-1:0] data_o,
    output logic             underrun_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [1:0]        bank_full_r;
    logic              wr_bank_r;
    logic [AW-1:0]     wr_ptr_r;
    logic              rd_bank_r;
    logic [AW-1:0]     rd_ptr_r;
    logic              rd_half_r;
    logic [PIX_W-1:0]  data_r;
    logic              underrun_r;

    logic              wr_ready_s;
    logic              wr_fire_s;
    logic              wr_last_s;
    logic              rd_hit_s;
    logic              rd_last_s;
    logic [1:0]        bank_set_s;
    logic [1:0]        bank_clr_s;
    logic [PAIR_W-1:0] wr_pair_s;
    logic [PAIR_W-1:0] rd_word_s;
    logic [PIX_W-1:0]  rd_pix_s;
    logic              unused_s;

    assign wr_ready_s = ~rst & ~frame_start_i & ~bank_full_r[wr_bank_r];
    assign wr_fire_s  = wr_valid_i & wr_ready_s;
    assign wr_last_s  = wr_fire_s & (wr_ptr_r == PTR_LAST);
    assign rd_hit_s   = data_req_i & bank_full_r[rd_bank_r];
    assign rd_last_s  = rd_hit_s & rd_half_r & (rd_ptr_r == PTR_LAST);
    assign wr_pair_s  = {wr_data_i[PIX1_LSB +: PIX_W], wr_data_i[PIX0_LSB +: PIX_W]};
    assign rd_pix_s   = rd_half_r ? rd_word_s[PIX_W +: PIX_W] : rd_word_s[0 +: PIX_W];
    assign unused_s   = ^{wr_data_i[31:28], wr_data_i[15:12]};

    assign wr_ready_o = wr_ready_s;
    assign data_o     = data_r;
    assign underrun_o = underrun_r;

    vga_pp_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire_s),
        .waddr ({wr_bank_r, wr_ptr_r}),
        .wdata (wr_pair_s),
        .raddr ({rd_bank_r, rd_ptr_r}),
        .rdata (rd_word_s)
    );

    // Per-bank full flag set/clear; write and read never target the same bank
    always_comb begin
        bank_set_s = 2'b00;
        bank_clr_s = 2'b00;
        if (wr_last_s) begin
            bank_set_s[wr_bank_r] = 1'b1;
        end else begin
            bank_set_s = 2'b00;
        end
        if (rd_last_s) begin
            bank_clr_s[rd_bank_r] = 1'b1;
        end else begin
            bank_clr_s = 2'b00;
        end
    end

    // Bank flags, pointers, pixel output and sticky underrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full_r <= 2'b00;
            wr_bank_r   <= 1'b0;
            wr_ptr_r    <= {AW{1'b0}};
            rd_bank_r   <= 1'b0;
            rd_ptr_r    <= {AW{1'b0}};
            rd_half_r   <= 1'b0;
            data_r      <= {PIX_W{1'b0}};
            underrun_r  <= 1'b0;
        end else if (frame_start_i) begin
            bank_full_r <= 2'b00;
            wr_bank_r   <= 1'b0;
            wr_ptr_r    <= {AW{1'b0}};
            rd_bank_r   <= 1'b0;
            rd_ptr_r    <= {AW{1'b0}};
            rd_half_r   <= 1'b0;
            data_r      <= {PIX_W{1'b0}};
            underrun_r  <= 1'b0;
        end else begin
            bank_full_r <= (bank_full_r | bank_set_s) & ~bank_clr_s;
            if (wr_fire_s) begin
                if (wr_last_s) begin
                    wr_bank_r <= ~wr_bank_r;
                    wr_ptr_r  <= {AW{1'b0}};
                end else begin
                    wr_ptr_r  <= wr_ptr_r + PTR_ONE;
                end
            end
            if (data_req_i) begin
                if (rd_hit_s) begin
                    data_r    <= rd_pix_s;
                    rd_half_r <= ~rd_half_r;
                    // Word pointer advances only after the upper pixel
                    if (rd_half_r) begin
                        if (rd_last_s) begin
                            rd_bank_r <= ~rd_bank_r;
                            rd_ptr_r  <= {AW{1'b0}};
                        end else begin
                            rd_ptr_r  <= rd_ptr_r + PTR_ONE;
                        end
                    end
                end else begin
                    data_r     <= {PIX_W{1'b0}};
                    underrun_r <= 1'b1;
                end
            end
        end
    end

endmodule
